// File: rtl/req_encoder_32to5.sv
// req_encoder_32to5: serialises a sticky multi-hot request set into one
// register number per transfer over a valid/ready handshake.
//   - pending collects req_in; one bit is retired each time the output
//     stage is (re)loaded.
//   - out_onehot is decoded from the registered index, so it always matches
//     the register-select decoder for out_index.
// Optional feature: define RR_PRIORITY_EN for round-robin selection starting
// at rr_ptr (reset value RR_RESET_PTR). The default build picks the lowest
// pending index.

// One decoder output bit: high when the output stage holds index IDX.
module req_encoder_32to5_dec_bit #(
  parameter logic [4:0] IDX = 5'd0
) (
  input  logic       en,
  input  logic [4:0] index,
  output logic       hit
);
  assign hit = en & (index == IDX);
endmodule

module req_encoder_32to5 #(
  parameter logic [4:0] RR_RESET_PTR = 5'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_in,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_index,
  output logic [31:0] out_onehot,
  output logic        pending_any
);
  localparam int NUM_REQ = 32;

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] pending_nxt;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [4:0]         sel;
  logic               sel_vld;
  logic               accept;
  logic               load;

  // Index of the lowest set bit; 0 when nothing is set (callers gate on sel_vld).
  function automatic logic [4:0] lsb_idx(input logic [NUM_REQ-1:0] v);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  assign accept  = out_valid & out_ready;
  assign load    = ~out_valid | accept;
  assign sel_vld = |pending;

`ifdef RR_PRIORITY_EN
  logic [4:0]         rr_ptr;
  logic [NUM_REQ-1:0] rot;
  logic [4:0]         rot_idx;

  // Rotate pending so rr_ptr lands at bit 0; the lowest set bit of the
  // rotated word is then the first request at or above rr_ptr (with wrap).
  assign rot     = (pending >> rr_ptr) | (pending << (6'd32 - {1'b0, rr_ptr}));
  assign rot_idx = lsb_idx(rot);
  assign sel     = rot_idx + rr_ptr;

  // Pointer moves just past every index that is loaded into the output stage;
  // flush leaves it alone so fairness survives a pipeline clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          rr_ptr <= RR_RESET_PTR;
    else if (!flush && load && sel_vld) rr_ptr <= sel + 5'd1;
  end
`else
  logic [4:0] rr_reset_unused;

  // Fixed priority: lowest pending index wins. The reset pointer has no role.
  assign rr_reset_unused = RR_RESET_PTR;
  assign sel             = lsb_idx(pending);
`endif

  assign sel_onehot = sel_vld ? (32'd1 << sel) : '0;

  // Next pending set. The retired bit is cleared before req_in is merged so
  // a request for the index being handed out re-arms it for a later pass.
  always_comb begin
    pending_nxt = pending | req_in;
    if (flush)     pending_nxt = '0;
    else if (load) pending_nxt = (pending & ~sel_onehot) | req_in;
  end

  // Pending set, its registered non-empty flag, and the output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending     <= '0;
      pending_any <= 1'b0;
      out_valid   <= 1'b0;
      out_index   <= 5'd0;
    end else begin
      pending     <= pending_nxt;
      pending_any <= |pending_nxt;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (load) begin
        out_valid <= sel_vld;
        if (sel_vld) out_index <= sel;
      end
    end
  end

  // One decoder cell per output bit; all zero while out_valid is low.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_dec
    req_encoder_32to5_dec_bit #(.IDX(5'(g))) u_dec (
      .en    (out_valid),
      .index (out_index),
      .hit   (out_onehot[g])
    );
  end
endmodule

// File: tb/tb_req_encoder_32to5.sv
// Scoreboard bench for req_encoder_32to5: stimulus pushes expected indices,
// a negedge monitor pops and compares on every accepted transfer.
module tb_req_encoder_32to5;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_in;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_index;
  logic [31:0] out_onehot;
  logic        pending_any;

  logic [4:0]  exp_q[$];
  logic [4:0]  mon_exp;
  int          tests = 0;
  int          fails = 0;
  int          mon_tests = 0;
  int          mon_fails = 0;
  logic        bad;

  req_encoder_32to5 #(.RR_RESET_PTR(5'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_in      (req_in),
    .flush       (flush),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_index   (out_index),
    .out_onehot  (out_onehot),
    .pending_any (pending_any)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      mon_tests++;
      if (exp_q.size() == 0) begin
        mon_fails++;
        $display("FAIL unexpected_out: got index %0d, expected no transfer", out_index);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_index !== mon_exp || out_onehot !== (32'd1 << mon_exp)) begin
          mon_fails++;
          $display("FAIL sb_out: got index %0d onehot %h, expected index %0d onehot %h",
                   out_index, out_onehot, mon_exp, 32'd1 << mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_in = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_onehot",  out_onehot,           32'd0);
    chk("rst_pendany", {31'd0, pending_any}, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a cycle with a request held in the output stage.
    req_in = 32'h0000_00F0; step(); req_in = '0;
    chk("mid_pendany", {31'd0, pending_any}, 32'd1);
    step();
    chk("mid_valid",   {31'd0, out_valid}, 32'd1);
    chk("mid_index",   {27'd0, out_index}, 32'd4);
    #3 reset = 1'b1;
    #1;
    chk("async_valid",   {31'd0, out_valid},   32'd0);
    chk("async_onehot",  out_onehot,           32'd0);
    chk("async_pendany", {31'd0, pending_any}, 32'd0);
    step(); reset = 1'b0; out_ready = 1'b1;
    bad = 1'b0;
    repeat (5) begin step(); if (out_valid) bad = 1'b1; end
    chk("post_rst_idle", {31'd0, bad}, 32'd0);

    // Single request: visible two edges after it is driven.
    req_in = 32'h0000_0400; exp_q.push_back(5'd10); step(); req_in = '0;
    chk("lat_early",  {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid",  {31'd0, out_valid}, 32'd1);
    chk("lat_index",  {27'd0, out_index}, 32'd10);
    chk("lat_onehot", out_onehot,         32'h0000_0400);
    step();
    chk("lat_done",   {31'd0, out_valid}, 32'd0);

    // Burst drains lowest-first, one per cycle.
    do_reset(); out_ready = 1'b1;
    req_in = 32'h8000_0025;
    exp_q.push_back(5'd0); exp_q.push_back(5'd2); exp_q.push_back(5'd5); exp_q.push_back(5'd31);
    step(); req_in = '0;
    repeat (5) step();
    chk("burst_valid", {31'd0, out_valid}, 32'd0);
    chk("burst_q",     32'(exp_q.size()),  32'd0);

    // Backpressure: output holds while a new request merges underneath.
    do_reset(); out_ready = 1'b0;
    req_in = 32'h8000_0025;
    exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd2);
    exp_q.push_back(5'd5); exp_q.push_back(5'd31);
    step(); req_in = '0;
    step();
    chk("stall1_idx", {26'd0, out_valid, out_index}, {26'd0, 1'b1, 5'd0});
    req_in = 32'h0000_0002;
    step(); req_in = '0;
    chk("stall2_idx", {26'd0, out_valid, out_index}, {26'd0, 1'b1, 5'd0});
    chk("stall2_oh",  out_onehot, 32'h0000_0001);
    step();
    chk("stall3_idx", {26'd0, out_valid, out_index}, {26'd0, 1'b1, 5'd0});
    out_ready = 1'b1;
    repeat (6) step();
    chk("bp_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_q",     32'(exp_q.size()),  32'd0);

    // Flush drops the held index, pending bits and the same-cycle request.
    do_reset(); out_ready = 1'b0;
    req_in = 32'h0000_0001; step(); req_in = '0;
    step();
    req_in = 32'h0000_0F00; step();
    chk("fl_setup_valid", {31'd0, out_valid},   32'd1);
    chk("fl_setup_pend",  {31'd0, pending_any}, 32'd1);
    req_in = 32'h0000_0008; out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; req_in = '0;
    chk("fl_valid",   {31'd0, out_valid},   32'd0);
    chk("fl_pendany", {31'd0, pending_any}, 32'd0);
    bad = 1'b0;
    repeat (8) begin step(); if (out_valid) bad = 1'b1; end
    chk("fl_idle", {31'd0, bad}, 32'd0);

    // Two requests held high. Round-robin alternates; fixed priority keeps
    // re-selecting bit 0 because it is re-set every cycle, so bit 1 only
    // escapes once the requests stop.
    do_reset(); out_ready = 1'b1;
`ifdef RR_PRIORITY_EN
    exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd0);
    exp_q.push_back(5'd1); exp_q.push_back(5'd0);
`else
    exp_q.push_back(5'd0); exp_q.push_back(5'd0); exp_q.push_back(5'd0);
    exp_q.push_back(5'd0); exp_q.push_back(5'd1);
`endif
    req_in = 32'h0000_0003;
    repeat (4) step();
    req_in = '0;
    repeat (4) step();
    chk("hold_q", 32'(exp_q.size()), 32'd0);

    // Deliver 29 (pointer moves to 30), then bit 1 must be found via wrap.
    req_in = 32'h2000_0000; exp_q.push_back(5'd29); step(); req_in = '0;
    step();
    req_in = 32'h0000_0002; exp_q.push_back(5'd1); step(); req_in = '0;
    step();
    chk("wrap_idx", {26'd0, out_valid, out_index}, {26'd0, 1'b1, 5'd1});
    repeat (2) step();
    chk("final_q", 32'(exp_q.size()), 32'd0);

    tests += mon_tests;
    fails += mon_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
